mpy_8: RTL and testbench

Sequential 8x8 unsigned multiplier using a shift-add datapath with one partial-product step per clock. It watches its operand inputs continuously: when either operand changes, it recomputes automatically, with no start or valid handshake. The 16-bit registered product holds the last completed result until the next computation finishes. It is a standalone arithmetic leaf block, driven by operands that change on clock edges and sampled by a consumer that waits a fixed settling window.

---
 rtl/mpy_8.sv | 63 ++++++
 tb/tb_mpy_8.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mpy_8.sv
// rtl/mpy_8.sv - Sequential 8x8 unsigned shift-add multiplier, self-triggered on operand change
module mpy_8 (
    input  logic        clk,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    input  logic        rst
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic [15:0] addend;

    assign addend = mplier[0] ? mcand : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            mcand   <= 16'h0000;
            mplier  <= 8'h00;
            acc     <= 16'h0000;
            cnt     <= 3'd0;
            product <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    // Captured operands double as the "last computed" tag for change detection
                    if ({a, b} != {a_q, b_q}) begin
                        a_q    <= a;
                        b_q    <= b;
                        mcand  <= {8'h00, a};
                        mplier <= b;
                        acc    <= 16'h0000;
                        cnt    <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc + addend;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= acc + addend;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpy_8.sv
// tb/tb_mpy_8.sv - Directed self-checking bench for mpy_8
module tb_mpy_8;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;
    bit x_seen = 0;

    mpy_8 dut (
        .clk     (clk),
        .a       (a),
        .b       (b),
        .product (product),
        .rst     (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1ns past the last edge for sampling/driving
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!rst && $isunknown(product)) x_seen = 1;
        end
    endtask

    initial begin
        logic [15:0] held;
        bit          stable;
        logic [7:0]  ra;
        logic [7:0]  rb;

        rst = 1'b1;
        a   = 8'h5A;
        b   = 8'h3C;
        tick(1);
        check("reset_cycle1", product, 16'd0);
        tick(1);
        check("reset_cycle2", product, 16'd0);

        rst = 1'b0;
        tick(8);
        check("after_reset_e7", product, 16'd0);
        tick(1);
        check("after_reset_e8", product, 16'd5400);

        a = 8'd255; b = 8'd255;
        tick(9);
        check("max_255x255", product, 16'd65025);
        stable = 1;
        for (int i = 0; i < 21; i++) begin
            tick(1);
            if (product !== 16'd65025) stable = 0;
        end
        check("max_stable21", {15'd0, stable}, 16'd1);

        a = 8'd0; b = 8'd200;
        tick(9);
        check("zero_times_200", product, 16'd0);

        a = 8'd1; b = 8'd255;
        tick(9);
        check("one_times_255", product, 16'd255);

        a = 8'd13; b = 8'd11;
        tick(9);
        check("hold_13x11", product, 16'd143);
        a = 8'd20; b = 8'd20;
        tick(8);
        check("hold_prev_8edges", product, 16'd143);
        tick(1);
        check("hold_new_20x20", product, 16'd400);
        tick(5);
        check("hold_20x20_stays", product, 16'd400);

        a = 8'd100; b = 8'd3;
        tick(4);
        a = 8'd7; b = 8'd9;
        tick(4);
        check("midrun_still_old", product, 16'd400);
        tick(1);
        check("midrun_first_300", product, 16'd300);
        tick(8);
        check("midrun_before_63", product, 16'd300);
        tick(1);
        check("midrun_then_63", product, 16'd63);

        a = 8'd200; b = 8'd150;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("midop_reset", product, 16'd0);
        rst = 1'b0;
        tick(8);
        check("post_abort_e7", product, 16'd0);
        tick(1);
        check("post_abort_30000", product, 16'd30000);

        // Reset together with an operand change: the change is loaded after release
        a = 8'd12; b = 8'd12;
        rst = 1'b1;
        tick(1);
        check("rst_wins", product, 16'd0);
        rst = 1'b0;
        tick(9);
        check("rst_then_144", product, 16'd144);

        held = product;
        for (int k = 0; k < 10; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            a = ra; b = rb;
            tick(21);
            check($sformatf("rand%0d_%0dx%0d", k, ra, rb), product, 16'(ra) * 16'(rb));
        end

        check("no_x_after_reset", {15'd0, x_seen}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
